// File: rtl/uart_pkg.sv
// Shared UART definitions for the TX control unit (and the RX unit once it moves here).
// Parity-related items are only referenced when UART_TX_PARITY_EN is defined.
package uart_pkg;

    localparam int DATA_BITS            = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 5208;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_e;

    // Even sense makes the total count of ones (data + parity) even; odd sense makes it odd.
    function automatic logic parity_bit(input logic [DATA_BITS-1:0] data, input logic odd);
        return odd ? ~^data : ^data;
    endfunction

endpackage

// File: rtl/uart_tx_ctl_if.sv
// Request/status bundle between the byte producer and the UART transmitter.
// A request transfers on a clk edge where start=1 and ready=1; start is ignored otherwise.
interface uart_tx_ctl_if;
    import uart_pkg::*;

    logic                 start;
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx;
    logic                 ready;
    logic                 busy;
    logic                 done;
    tx_state_e            state;

    modport master (
        output start, tx_data,
        input  tx, ready, busy, done, state
    );

    modport slave (
        input  start, tx_data,
        output tx, ready, busy, done, state
    );

endinterface

// File: rtl/uart_baud_counter.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled, ticks on the last count.
// Shared between the TX and RX control units.
module uart_baud_counter #(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic bit_tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign bit_tick = enable && (cnt == LAST);

endmodule

// File: rtl/uart_tx_ctl.sv
// UART transmitter: start bit, 8 data bits LSB-first, optional parity, one stop bit.
// Define UART_TX_PARITY_EN for 8E1/8O1 framing (sense from PARITY_ODD); default is 8N1.
module uart_tx_ctl
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int PARITY_ODD   = 0
) (
    input  logic           clk,
    input  logic           reset,
    uart_tx_ctl_if.slave   bus
);

    tx_state_e            state;
    logic [DATA_BITS-1:0] shift;
    logic [2:0]           bit_idx;
    logic                 tx_r;
    logic                 ready_r;
    logic                 busy_r;
    logic                 done_r;
    logic                 bit_tick;
    logic                 baud_en;
    logic                 baud_clear;
`ifdef UART_TX_PARITY_EN
    logic                 parity_r;
`endif

    // Every tick ends the current serial bit, so the counter restarts on each one.
    assign baud_en    = (state != TX_IDLE);
    assign baud_clear = bit_tick || !baud_en;

    uart_baud_counter #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk      (clk),
        .reset    (reset),
        .clear    (baud_clear),
        .enable   (baud_en),
        .bit_tick (bit_tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= TX_IDLE;
            shift    <= '0;
            bit_idx  <= '0;
            tx_r     <= 1'b1;
            ready_r  <= 1'b1;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_r <= 1'b0;
`endif
        end else begin
            done_r <= 1'b0;
            case (state)
                TX_IDLE: begin
                    tx_r    <= 1'b1;
                    ready_r <= 1'b1;
                    busy_r  <= 1'b0;
                    if (bus.start) begin
                        shift    <= bus.tx_data;
`ifdef UART_TX_PARITY_EN
                        parity_r <= parity_bit(bus.tx_data, PARITY_ODD != 0);
`endif
                        bit_idx  <= '0;
                        state    <= TX_START;
                        tx_r     <= 1'b0;
                        ready_r  <= 1'b0;
                        busy_r   <= 1'b1;
                    end
                end
                TX_START: begin
                    if (bit_tick) begin
                        state   <= TX_DATA;
                        bit_idx <= '0;
                        tx_r    <= shift[0];
                    end
                end
                TX_DATA: begin
                    if (bit_tick) begin
                        if (bit_idx != 3'(DATA_BITS - 1)) begin
                            // Line already carries shift[0]; present the next bit as we shift.
                            shift   <= shift >> 1;
                            tx_r    <= shift[1];
                            bit_idx <= bit_idx + 3'd1;
                        end else begin
`ifdef UART_TX_PARITY_EN
                            state <= TX_PARITY;
                            tx_r  <= parity_r;
`else
                            state <= TX_STOP;
                            tx_r  <= 1'b1;
`endif
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                TX_PARITY: begin
                    if (bit_tick) begin
                        state <= TX_STOP;
                        tx_r  <= 1'b1;
                    end
                end
`endif
                TX_STOP: begin
                    if (bit_tick) begin
                        state   <= TX_IDLE;
                        tx_r    <= 1'b1;
                        ready_r <= 1'b1;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end
                end
                default: begin
                    state   <= TX_IDLE;
                    bit_idx <= '0;
                    tx_r    <= 1'b1;
                    ready_r <= 1'b1;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.tx    = tx_r;
    assign bus.ready = ready_r;
    assign bus.busy  = busy_r;
    assign bus.done  = done_r;
    assign bus.state = state;

endmodule

// File: tb/tb_uart_tx_ctl.sv
// Bench for uart_tx_ctl at CLKS_PER_BIT=4: table vectors, corner sequences, random frames.
module tb_uart_tx_ctl;
    import uart_pkg::*;

    localparam int CPB     = 4;
    localparam int PAR_ODD = 0;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int NO_POKE = -10;

    typedef struct {
        logic [7:0] data;
        logic       par_even;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic exp_q[$];
    vec_t vecs[6];

    uart_tx_ctl_if bus();

    uart_tx_ctl #(
        .CLKS_PER_BIT (CPB),
        .PARITY_ODD   (PAR_ODD)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference frame: idle-low start, data LSB first, parity chosen from the ones count, stop high.
    task automatic model_frame(input logic [7:0] d);
        int ones;
        ones = 0;
        exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(d[i]);
            if (d[i]) ones++;
        end
        if (FRAME_BITS == 11) begin
            if (PAR_ODD == 0) exp_q.push_back(logic'(ones % 2));
            else              exp_q.push_back(logic'((ones + 1) % 2));
        end
        exp_q.push_back(1'b1);
    endtask

    task automatic table_frame(input vec_t v);
        exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_q.push_back(v.data[i]);
        if (FRAME_BITS == 11) exp_q.push_back(PAR_ODD == 0 ? v.par_even : ~v.par_even);
        exp_q.push_back(1'b1);
    endtask

    // Called at a negedge; returns at the negedge of the first cycle after acceptance.
    task automatic drive_start(input logic [7:0] d);
        check("accept.ready", bus.ready, 1'b1);
        bus.start   = 1'b1;
        bus.tx_data = d;
        @(posedge clk);
        @(negedge clk);
        bus.start   = 1'b0;
        bus.tx_data = 8'($urandom());
    endtask

    // Checks every cycle of the frame, then the done cycle; returns at the done-cycle negedge.
    task automatic check_frame(input string name, input int poke_cycle);
        logic bit_v;
        int   cyc;
        for (int b = 0; b < FRAME_BITS; b++) begin
            if (exp_q.size() == 0) begin
                check({name, ".exp_q_empty"}, 32'd0, 32'd1);
                bit_v = 1'b1;
            end else begin
                bit_v = exp_q.pop_front();
            end
            for (int c = 0; c < CPB; c++) begin
                cyc = b * CPB + c + 1;
                check({name, ".tx"},    bus.tx,    bit_v);
                check({name, ".busy"},  bus.busy,  1'b1);
                check({name, ".ready"}, bus.ready, 1'b0);
                check({name, ".done"},  bus.done,  1'b0);
                if (cyc == poke_cycle) begin
                    bus.start   = 1'b1;
                    bus.tx_data = 8'h3C;
                end else if (cyc == poke_cycle + 1) begin
                    bus.start = 1'b0;
                end
                @(negedge clk);
            end
        end
        check({name, ".done_pulse"}, bus.done,  1'b1);
        check({name, ".done_ready"}, bus.ready, 1'b1);
        check({name, ".done_busy"},  bus.busy,  1'b0);
        check({name, ".done_tx"},    bus.tx,    1'b1);
    endtask

    task automatic check_idle(input string name, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            check({name, ".tx"},    bus.tx,    1'b1);
            check({name, ".ready"}, bus.ready, 1'b1);
            check({name, ".busy"},  bus.busy,  1'b0);
            check({name, ".done"},  bus.done,  1'b0);
        end
    endtask

    initial begin
        int gap;
        logic [7:0] d;

        vecs[0] = '{data: 8'hA5, par_even: 1'b0};
        vecs[1] = '{data: 8'h07, par_even: 1'b1};
        vecs[2] = '{data: 8'h00, par_even: 1'b0};
        vecs[3] = '{data: 8'hFF, par_even: 1'b0};
        vecs[4] = '{data: 8'h01, par_even: 1'b1};
        vecs[5] = '{data: 8'h6E, par_even: 1'b1};

        reset       = 1'b1;
        bus.start   = 1'b0;
        bus.tx_data = 8'h00;
        repeat (3) @(negedge clk);
        check("reset.tx",    bus.tx,    1'b1);
        check("reset.ready", bus.ready, 1'b1);
        check("reset.busy",  bus.busy,  1'b0);
        check("reset.done",  bus.done,  1'b0);
        check("reset.state", 32'(bus.state), 32'(TX_IDLE));
        reset = 1'b0;
        check_idle("idle50", 50);

        foreach (vecs[i]) begin
            table_frame(vecs[i]);
            drive_start(vecs[i].data);
            check_frame($sformatf("vec%0d", i), NO_POKE);
            @(negedge clk);
            check("vec.done_low", bus.done, 1'b0);
        end

        // Back-to-back: second request raised on the done cycle.
        model_frame(8'h00);
        drive_start(8'h00);
        check_frame("b2b_first", NO_POKE);
        model_frame(8'hFF);
        drive_start(8'hFF);
        check_frame("b2b_second", NO_POKE);
        @(negedge clk);
        check("b2b.done_low", bus.done, 1'b0);

        // Request during a frame must be ignored.
        model_frame(8'h81);
        drive_start(8'h81);
        check_frame("poke", 10);
        check_idle("poke_after", 3 * CPB);

        // Reset during data bit 3 (cycles 17..20 after acceptance).
        drive_start(8'h81);
        repeat (17) @(negedge clk);
        check("abort.in_bit3", bus.tx, 1'b0);
        check("abort.busy_before", bus.busy, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        check("abort.tx",    bus.tx,    1'b1);
        check("abort.busy",  bus.busy,  1'b0);
        check("abort.ready", bus.ready, 1'b1);
        check("abort.done",  bus.done,  1'b0);
        reset = 1'b0;
        check_idle("abort_after", 2 * CPB);
        model_frame(8'h55);
        drive_start(8'h55);
        check_frame("clean55", NO_POKE);

        // Random bytes with random idle gaps (gap 0 means start on the done cycle).
        for (int n = 0; n < 12; n++) begin
            gap = $urandom_range(0, 3);
            if (gap > 0) check_idle("rand_gap", gap);
            d = 8'($urandom());
            model_frame(d);
            drive_start(d);
            check_frame($sformatf("rand%0d_%02h", n, d), NO_POKE);
        end
        @(negedge clk);
        check("rand.done_low", bus.done, 1'b0);
        check("final.exp_q_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
